acq_buffer_reader: RTL

ACQ_BUFFER_READER -- requirements
Module: acq_buffer_reader

---
 rtl/acq_pkg.sv | 34 +++
 rtl/acq_byte_tx.sv | 40 ++++
 rtl/acq_buffer_reader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition buffer reader.
// Holds the frame marker/channel ID bytes, the default buffer geometry,
// the reader FSM encoding and the count saturation helper.
package acq_pkg;

  localparam int DEPTH_DEF  = 1024;
  localparam int IDX_W_DEF  = 10;
  localparam int DATA_W_DEF = 14;

  localparam logic [7:0] SOF_BYTE = 8'hA5;
  localparam logic [7:0] CHID_A   = 8'h0A;
  localparam logic [7:0] CHID_B   = 8'h0B;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_CHID,
    ST_CNT_H,
    ST_CNT_L,
    ST_FETCH,
    ST_WAIT,
    ST_DATA_H,
    ST_DATA_L,
    ST_CSUM,
    ST_ACK
  } state_t;

  // Clamp a reported sample count to the physical buffer depth.
  function automatic logic [10:0] sat_count(input logic [10:0] cnt,
                                            input logic [10:0] lim);
    return (cnt > lim) ? lim : cnt;
  endfunction

endpackage

// File: rtl/acq_byte_tx.sv
// Single-entry byte holding register toward the host link.
// A loaded byte is presented with o_valid until the sink accepts it; the
// byte and valid are frozen while the sink stalls.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   i_load, i_byte  - load a new byte (only when empty or being accepted)
//   i_ready         - sink ready
//   o_valid, o_data - byte stream toward the sink
//   o_xfer          - this cycle completes a transfer
module acq_byte_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_xfer
);

  logic       r_valid;
  logic [7:0] r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_byte;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_xfer  = r_valid & i_ready;

endmodule

// File: rtl/acq_buffer_reader.sv
// Reads captured sample buffers of channels A/B and streams each one to the
// host as a checksummed byte frame, then acknowledges the buffer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a ready buffer; picks channel round-robin
// HDR     | presenting 0xA5
// CHID    | presenting channel ID
// CNT_H   | presenting count[10:8]
// CNT_L   | presenting count[7:0]
// FETCH   | read_index driven with the sample counter
// WAIT    | buffer read latency; sample latched at end of this cycle
// DATA_H  | presenting {2'b00, sample[13:8]}
// DATA_L  | presenting sample[7:0]
// CSUM    | presenting XOR checksum
// ACK     | one-cycle ack pulse for the served channel
//
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   buffer_ready_A/B, count_A/B      - buffer status from the samplers
//   read_index, sampled_data_A/B     - shared buffer read port (1-cycle latency)
//   tx_data, tx_valid, tx_ready      - byte stream toward the host link
//   ack_A/B                          - buffer consumed pulse
//   busy                             - frame in progress
module acq_buffer_reader
  import acq_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              buffer_ready_A,
  input  logic              buffer_ready_B,
  input  logic [10:0]       count_A,
  input  logic [10:0]       count_B,
  output logic [IDX_W-1:0]  read_index,
  input  logic [DATA_W-1:0] sampled_data_A,
  input  logic [DATA_W-1:0] sampled_data_B,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              ack_A,
  output logic              ack_B,
  output logic              busy
);

  state_t            r_state;
  state_t            w_next;
  logic              r_sel_b;
  logic              r_rr_b;
  logic [10:0]       r_count;
  logic [IDX_W-1:0]  r_smp;
  logic [7:0]        r_csum;
  logic [7:0]        r_lo;

  logic              w_xfer;
  logic              w_load;
  logic [7:0]        w_byte;
  logic              w_pick_b;
  logic              w_last;
  logic [DATA_W-1:0] w_sample;

  // B wins only if A is absent or A was served last.
  assign w_pick_b = buffer_ready_B & (~buffer_ready_A | r_rr_b);
  assign w_last   = (11'(r_smp) == (r_count - 11'd1));
  assign w_sample = r_sel_b ? sampled_data_B : sampled_data_A;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (buffer_ready_A || buffer_ready_B) w_next = ST_HDR;
      ST_HDR:    if (w_xfer) w_next = ST_CHID;
      ST_CHID:   if (w_xfer) w_next = ST_CNT_H;
      ST_CNT_H:  if (w_xfer) w_next = ST_CNT_L;
      ST_CNT_L:  if (w_xfer) w_next = (r_count == 11'd0) ? ST_CSUM : ST_FETCH;
      ST_FETCH:  w_next = ST_WAIT;
      ST_WAIT:   w_next = ST_DATA_H;
      ST_DATA_H: if (w_xfer) w_next = ST_DATA_L;
      ST_DATA_L: if (w_xfer) w_next = w_last ? ST_CSUM : ST_FETCH;
      ST_CSUM:   if (w_xfer) w_next = ST_ACK;
      ST_ACK:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Each byte state's byte is loaded on the edge that enters it, so it is
  // already valid during the state and a full-rate sink costs 1 cycle/byte.
  always_comb begin
    w_load = 1'b0;
    w_byte = 8'h00;
    busy   = (r_state != ST_IDLE);
    ack_A  = (r_state == ST_ACK) & ~r_sel_b;
    ack_B  = (r_state == ST_ACK) &  r_sel_b;
    if (w_next != r_state) begin
      case (w_next)
        ST_HDR:    begin w_load = 1'b1; w_byte = SOF_BYTE; end
        ST_CHID:   begin w_load = 1'b1; w_byte = r_sel_b ? CHID_B : CHID_A; end
        ST_CNT_H:  begin w_load = 1'b1; w_byte = {5'd0, r_count[10:8]}; end
        ST_CNT_L:  begin w_load = 1'b1; w_byte = r_count[7:0]; end
        ST_DATA_H: begin w_load = 1'b1; w_byte = {2'b00, w_sample[13:8]}; end
        ST_DATA_L: begin w_load = 1'b1; w_byte = r_lo; end
        ST_CSUM:   begin w_load = 1'b1; w_byte = r_csum; end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_b <= 1'b0;
      r_rr_b  <= 1'b0;
      r_count <= 11'd0;
      r_smp   <= '0;
      r_csum  <= 8'h00;
      r_lo    <= 8'h00;
    end else begin
      if (r_state == ST_IDLE && w_next == ST_HDR) begin
        r_sel_b <= w_pick_b;
        r_rr_b  <= ~w_pick_b;
        r_count <= sat_count(w_pick_b ? count_B : count_A, 11'(DEPTH));
      end
      if (r_state == ST_WAIT) r_lo <= w_sample[7:0];
      if (r_state == ST_DATA_L && w_xfer && !w_last) r_smp <= r_smp + IDX_W'(1);
      // Counter parks at 0 between frames so an empty frame never moves read_index.
      if (r_state == ST_ACK) r_smp <= '0;
      if (r_state == ST_IDLE) r_csum <= 8'h00;
      else if (w_load && w_next != ST_CSUM) r_csum <= r_csum ^ w_byte;
    end
  end

  assign read_index = r_smp;

  acq_byte_tx u_tx (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_byte  (w_byte),
    .i_ready (tx_ready),
    .o_valid (tx_valid),
    .o_data  (tx_data),
    .o_xfer  (w_xfer)
  );

endmodule
